smvm_stream_encoder: RTL and testbench
======================================

Name: smvm_stream_encoder

Overview:
- Upstream stage of the SMVM datapath. Accepts a dense frame (header, vector, row-major dense matrix) over a valid/ready byte stream.
- Compresses the matrix to nonzero (value, column, row-end) entries and pads the entry count to a multiple of K.
- Replays the whole frame as the gap-free serialized protocol the SMVM core consumes on its val_in/col_in/ipv_in/in_valid inputs. The core has no backpressure, so emission starts only after the frame is fully buffered.

Parameters:
- K, 4, ALU group size; the entry count is padded to a multiple of K.
- MAX_COLS, 128, vector buffer depth; legal cols is 1..MAX_COLS.
- MAX_NNZ, 256, entry FIFO depth, including padding and empty-row entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input byte valid
- s_data  in  8  input byte (unsigned for header bytes, signed for data bytes)
- s_ready  out  1  encoder accepts s_data this cycle
- val_out  out  8  to SMVM val_in
- col_out  out  3  to SMVM col_in
- ipv_out  out  1  to SMVM ipv_in
- out_valid  out  1  to SMVM in_valid
- busy  out  1  a frame is in progress (any state other than IDLE)
- done  out  1  one-cycle pulse after the last emitted word
- err  out  1  sticky error flag; cleared by the next accepted header byte

Behaviour:
- Reset: state IDLE; s_ready=1; val_out=0, col_out=0, ipv_out=0, out_valid=0, busy=0, done=0, err=0; all counters 0.
- Input transfer occurs when s_valid && s_ready. s_ready=1 only in IDLE, LD_COLS, LD_VEC, LD_MAT.
- 12-bit word packing for header and index words: {val_out, ipv_out, col_out} = {4'b0, X[7:0]}, i.e. col_out=X[2:0], ipv_out=X[3], val_out={4'b0, X[7:4]}.
- State IDLE: on transfer, latch rows=s_data and clear err -> LD_COLS. If rows==0, set err and stay in IDLE.
- State LD_COLS: on transfer, latch cols -> LD_VEC. If cols==0 or cols>MAX_COLS, set err -> IDLE.
- State LD_VEC: store cols bytes into vec_buf[0..cols-1] -> LD_MAT.
- State LD_MAT: accept rows*cols bytes with column counter c and row counter r.
  - Nonzero byte at (r,c): push entry {val=byte, col=c, ipv=(c==cols-1)}.
  - Zero byte at the last column: if the row had no nonzero, push {0, cols-1, 1}; otherwise set ipv=1 on the row's last pushed entry (in place, same cycle).
  - Result: every row yields exactly one ipv=1 entry, its last.
  - After the last byte -> PAD.
- State PAD: no input accepted. Push {0, 0, 0} one per cycle while nnz%K != 0, then -> EM_ROWS. With nnz%K==0 on entry, it spends exactly one cycle.
- Overflow: a push with nnz==MAX_NNZ is dropped and sets err. The frame is still fully consumed and emitted.
- Emission: out_valid=1 on every cycle from EM_ROWS through the last EM_IDX, with no bubbles.
  - EM_ROWS: packed rows word.
  - EM_COLS: packed cols word.
  - EM_VEC: vec_buf[0..cols-1] on val_out, col_out=0, ipv_out=0.
  - EM_VAL: val_out=entry.val, ipv_out=entry.ipv, col_out=0.
  - EM_IDX: packed entry.col word. EM_VAL and EM_IDX alternate for each entry in FIFO order.
  - After the last EM_IDX -> EM_END.
- State EM_END: out_valid=0, done=1 for one cycle -> IDLE. The next frame may be accepted the following cycle.
- Outputs are registered. val_out/col_out/ipv_out are driven to 0 whenever out_valid=0.
- Latency: the first emitted word appears 1 + pad_cycles cycles after the last matrix byte is accepted. pad_cycles is the PAD-state cycle count, 1..K.
- Emitted word count = 2 + cols + 2*nnz_padded.
- s_valid is ignored outside the load states. A reset mid-frame discards all buffered data.

Test Plan:
- rows=2, cols=3, vec={1,2,3}, mat={0,5,0, 7,0,-1}. Entries (5,c1,ipv1), (7,c0,ipv0), (-1,c2,ipv1), plus one pad (0,0,0). Required stream: 0x002, 0x003, 1, 2, 3, then [5|ipv1], 0x001, [7|ipv0], 0x000, [-1|ipv1], 0x002, [0|ipv0], 0x000. Then out_valid=0 with done=1.
- Empty row: rows=1, cols=2, mat={0,0}. Entries {0,c1,ipv1} plus 3 pads (K=4). Stream has 2+2+8 valid words; ipv_out=1 only on the first EM_VAL.
- Exact multiple of K: rows=1, cols=4, all ones. No pad entries; PAD lasts one cycle; first out_valid occurs 2 cycles after the last byte.
- Header errors: rows=0, then cols=200 on a new header. err=1 in both cases; the encoder returns to IDLE with no out_valid activity; the next valid frame clears err.
- Overflow: MAX_NNZ=8, rows=3, cols=4, all nonzero (12 entries). err=1, 8 entries emitted, done pulses.
- Input stalls and reset: random s_valid gaps during LD_MAT give an output identical to the no-gap case. rst_n low mid-EM_VEC gives out_valid=0 immediately and s_ready=1 after release.

Source files
------------

// File: rtl/smvm_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : smvm_stream_encoder
// Description : Buffers a dense byte-stream frame, compresses the matrix to
//               padded nonzero entries and replays it gap-free to the SMVM core.
// Revision    : 1.0 - initial release
// ============================================================================
module smvm_stream_encoder #(
    parameter int K        = 4,
    parameter int MAX_COLS = 128,
    parameter int MAX_NNZ  = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic [7:0] val_out,
    output logic [2:0] col_out,
    output logic       ipv_out,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int c_vec_aw = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int c_nnz_aw = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
    localparam int c_nnz_w  = $clog2(MAX_NNZ + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_COLS = 4'd1,
        S_LD_VEC  = 4'd2,
        S_LD_MAT  = 4'd3,
        S_PAD     = 4'd4,
        S_EM_ROWS = 4'd5,
        S_EM_COLS = 4'd6,
        S_EM_VEC  = 4'd7,
        S_EM_VAL  = 4'd8,
        S_EM_IDX  = 4'd9,
        S_EM_END  = 4'd10
    } state_t;

    state_t r_state, w_next_state;

    logic [7:0]         r_rows, r_cols, r_c, r_r, r_vidx;
    logic [c_nnz_w-1:0] r_nnz, r_rd;
    logic               r_row_pushed;
    logic               r_err;

    logic [7:0] r_vec_buf  [MAX_COLS];
    logic [7:0] r_fifo_val [MAX_NNZ];
    logic [7:0] r_fifo_col [MAX_NNZ];
    logic       r_fifo_ipv [MAX_NNZ];

    logic [7:0] r_val_out;
    logic [2:0] r_col_out;
    logic       r_ipv_out, r_out_valid, r_done;

    logic               w_xfer, w_last_col, w_last_row, w_last_vec, w_last_ent;
    logic               w_full, w_pad_need, w_cols_bad;
    logic               w_push, w_push_ok, w_patch, w_push_ipv;
    logic [7:0]         w_push_val, w_push_col;
    logic [c_nnz_w-1:0] w_nnz_m1;
    logic [c_nnz_aw-1:0] w_wr_idx, w_patch_idx, w_rd_idx;
    logic [7:0]         w_val;
    logic [2:0]         w_col;
    logic               w_ipv, w_ovld;

    assign s_ready = (r_state == S_IDLE) || (r_state == S_LD_COLS) ||
                     (r_state == S_LD_VEC) || (r_state == S_LD_MAT);
    assign busy    = (r_state != S_IDLE);
    assign err     = r_err;

    assign w_xfer      = s_valid && s_ready;
    assign w_last_col  = (r_c == r_cols - 8'd1);
    assign w_last_row  = (r_r == r_rows - 8'd1);
    assign w_last_vec  = (r_vidx == r_cols - 8'd1);
    assign w_nnz_m1    = r_nnz - c_nnz_w'(1);
    assign w_last_ent  = (r_rd == w_nnz_m1);
    assign w_full      = (r_nnz == c_nnz_w'(MAX_NNZ));
    assign w_pad_need  = ((r_nnz % c_nnz_w'(K)) != '0) && !w_full;
    assign w_cols_bad  = (s_data == 8'd0) || (int'(s_data) > MAX_COLS);
    assign w_wr_idx    = r_nnz[c_nnz_aw-1:0];
    assign w_patch_idx = w_nnz_m1[c_nnz_aw-1:0];
    assign w_rd_idx    = r_rd[c_nnz_aw-1:0];
    assign w_push_ok   = w_push && !w_full;

    // A zero at the last column either closes an empty row with a marker entry
    // or retro-flags the row's last stored entry as its row end.
    always_comb begin
        w_push     = 1'b0;
        w_patch    = 1'b0;
        w_push_val = s_data;
        w_push_col = r_c;
        w_push_ipv = w_last_col;
        if (r_state == S_LD_MAT && w_xfer) begin
            if (s_data != 8'd0) begin
                w_push = 1'b1;
            end else if (w_last_col) begin
                if (r_row_pushed) w_patch = 1'b1;
                else              w_push  = 1'b1;
            end
        end else if (r_state == S_PAD && w_pad_need) begin
            w_push     = 1'b1;
            w_push_val = 8'd0;
            w_push_col = 8'd0;
            w_push_ipv = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_xfer && s_data != 8'd0) w_next_state = S_LD_COLS;
            S_LD_COLS: if (w_xfer) w_next_state = w_cols_bad ? S_IDLE : S_LD_VEC;
            S_LD_VEC:  if (w_xfer && w_last_vec) w_next_state = S_LD_MAT;
            S_LD_MAT:  if (w_xfer && w_last_col && w_last_row) w_next_state = S_PAD;
            S_PAD:     if (!w_pad_need) w_next_state = S_EM_ROWS;
            S_EM_ROWS: w_next_state = S_EM_COLS;
            S_EM_COLS: w_next_state = S_EM_VEC;
            S_EM_VEC:  if (w_last_vec) w_next_state = (r_nnz == '0) ? S_EM_END : S_EM_VAL;
            S_EM_VAL:  w_next_state = S_EM_IDX;
            S_EM_IDX:  w_next_state = w_last_ent ? S_EM_END : S_EM_VAL;
            S_EM_END:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows       <= 8'd0;
            r_cols       <= 8'd0;
            r_c          <= 8'd0;
            r_r          <= 8'd0;
            r_vidx       <= 8'd0;
            r_nnz        <= '0;
            r_rd         <= '0;
            r_row_pushed <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_c          <= 8'd0;
                    r_r          <= 8'd0;
                    r_vidx       <= 8'd0;
                    r_nnz        <= '0;
                    r_rd         <= '0;
                    r_row_pushed <= 1'b0;
                    if (w_xfer) begin
                        r_rows <= s_data;
                        r_err  <= (s_data == 8'd0);
                    end
                end
                S_LD_COLS: begin
                    if (w_xfer) begin
                        r_cols <= s_data;
                        if (w_cols_bad) r_err <= 1'b1;
                    end
                end
                S_LD_VEC: begin
                    if (w_xfer) r_vidx <= w_last_vec ? 8'd0 : r_vidx + 8'd1;
                end
                S_LD_MAT: begin
                    if (w_xfer) begin
                        if (w_last_col) begin
                            r_c <= 8'd0;
                            r_r <= r_r + 8'd1;
                        end else begin
                            r_c <= r_c + 8'd1;
                        end
                        r_row_pushed <= w_last_col ? 1'b0 : (r_row_pushed || w_push_ok);
                    end
                end
                S_EM_VEC: r_vidx <= r_vidx + 8'd1;
                S_EM_IDX: r_rd   <= r_rd + c_nnz_w'(1);
                default: ;
            endcase
            if (w_push_ok)          r_nnz <= r_nnz + c_nnz_w'(1);
            if (w_push && w_full)   r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LD_VEC && w_xfer) r_vec_buf[r_vidx[c_vec_aw-1:0]] <= s_data;
        if (w_push_ok) begin
            r_fifo_val[w_wr_idx] <= w_push_val;
            r_fifo_col[w_wr_idx] <= w_push_col;
            r_fifo_ipv[w_wr_idx] <= w_push_ipv;
        end
        if (w_patch) r_fifo_ipv[w_patch_idx] <= 1'b1;
    end

    // Header and index words use the 12-bit packing {val, ipv, col} = {4'b0, X}.
    always_comb begin
        w_val  = 8'd0;
        w_ipv  = 1'b0;
        w_col  = 3'd0;
        w_ovld = 1'b0;
        case (r_state)
            S_EM_ROWS: begin
                w_ovld = 1'b1;
                {w_val, w_ipv, w_col} = {4'b0000, r_rows};
            end
            S_EM_COLS: begin
                w_ovld = 1'b1;
                {w_val, w_ipv, w_col} = {4'b0000, r_cols};
            end
            S_EM_VEC: begin
                w_ovld = 1'b1;
                w_val  = r_vec_buf[r_vidx[c_vec_aw-1:0]];
            end
            S_EM_VAL: begin
                w_ovld = 1'b1;
                w_val  = r_fifo_val[w_rd_idx];
                w_ipv  = r_fifo_ipv[w_rd_idx];
            end
            S_EM_IDX: begin
                w_ovld = 1'b1;
                {w_val, w_ipv, w_col} = {4'b0000, r_fifo_col[w_rd_idx]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val_out   <= 8'd0;
            r_col_out   <= 3'd0;
            r_ipv_out   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_val_out   <= w_val;
            r_col_out   <= w_col;
            r_ipv_out   <= w_ipv;
            r_out_valid <= w_ovld;
            r_done      <= (r_state == S_EM_END);
        end
    end

    assign val_out   = r_val_out;
    assign col_out   = r_col_out;
    assign ipv_out   = r_ipv_out;
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_smvm_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_smvm_stream_encoder
// Description : Scoreboard bench for smvm_stream_encoder with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smvm_stream_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] val_out;
    logic [2:0] col_out;
    logic       ipv_out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       err;

    int         total = 0;
    int         bad   = 0;
    int         sb[$];
    logic [7:0] stim[$];
    logic       mon_en;

    smvm_stream_encoder #(.K(4), .MAX_COLS(128), .MAX_NNZ(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .val_out(val_out), .col_out(col_out),
        .ipv_out(ipv_out), .out_valid(out_valid), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected item = {done, val, ipv, col}
    task automatic ew(input logic [7:0] v, input logic i);
        sb.push_back(int'({1'b0, v, i, 3'b000}));
    endtask
    task automatic ep(input logic [7:0] x);
        sb.push_back(int'({5'b00000, x}));
    endtask
    task automatic ed();
        sb.push_back(32'h1000);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && (out_valid || done)) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", int'({done, val_out, ipv_out, col_out}), -1);
                end else begin
                    check("stream_word", int'({done, val_out, ipv_out, col_out}), sb.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_all(input int maxgap);
        foreach (stim[i]) begin
            send(stim[i]);
            if (maxgap > 0 && i != stim.size() - 1)
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge clk);
                    #1;
                end
        end
    endtask

    task automatic measure(input string nm, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(nm, n, exp_lat);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", int'({sb.size() != 0, busy}), 0);
    endtask

    task automatic exp_frame1();
        ep(8'd2); ep(8'd3);
        ew(8'd1, 1'b0); ew(8'd2, 1'b0); ew(8'd3, 1'b0);
        ew(8'd5, 1'b1);    ep(8'd1);
        ew(8'd7, 1'b0);    ep(8'd0);
        ew(8'hFF, 1'b1);   ep(8'd2);
        ew(8'd0, 1'b0);    ep(8'd0);
        ed();
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        mon_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_flags", int'({out_valid, busy, done, err}), 0);
        check("rst_word", int'({val_out, ipv_out, col_out}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, two pad... one pad entry -> PAD 2 cycles
        exp_frame1();
        stim = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd0, 8'd5, 8'd0, 8'd7, 8'd0, 8'hFF};
        send_all(0);
        measure("latency_pad1", 3);
        drain();
        check("err_after_f1", err, 0);

        // Empty row: marker entry plus three pads
        ep(8'd1); ep(8'd2); ew(8'd9, 1'b0); ew(8'hFE, 1'b0);
        ew(8'd0, 1'b1); ep(8'd1);
        repeat (3) begin
            ew(8'd0, 1'b0); ep(8'd0);
        end
        ed();
        stim = '{8'd1, 8'd2, 8'd9, 8'hFE, 8'd0, 8'd0};
        send_all(0);
        measure("latency_pad3", 5);
        drain();

        // Header errors
        send(8'd0);
        check("err_rows0", int'({err, busy}), 2);
        send(8'd1);
        check("err_cleared_hdr", err, 0);
        send(8'd200);
        check("err_cols200", int'({err, busy}), 2);
        repeat (6) @(posedge clk);
        #1;
        check("err_idle_quiet", int'({out_valid, busy}), 0);

        // Stalled input reproduces frame 1 exactly
        exp_frame1();
        send(8'd2);
        check("err_clear_next", err, 0);
        stim = '{8'd3, 8'd1, 8'd2, 8'd3, 8'd0, 8'd5, 8'd0, 8'd7, 8'd0, 8'hFF};
        send_all(3);
        drain();

        // Overflow: 12 nonzeros into an 8-entry FIFO
        ep(8'd3); ep(8'd4);
        ew(8'd1, 1'b0); ew(8'd2, 1'b0); ew(8'd3, 1'b0); ew(8'd4, 1'b0);
        ew(8'd1, 1'b0); ep(8'd0); ew(8'd2, 1'b0); ep(8'd1);
        ew(8'd3, 1'b0); ep(8'd2); ew(8'd4, 1'b1); ep(8'd3);
        ew(8'd5, 1'b0); ep(8'd0); ew(8'd6, 1'b0); ep(8'd1);
        ew(8'd7, 1'b0); ep(8'd2); ew(8'd8, 1'b1); ep(8'd3);
        ed();
        stim = '{8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4,
                 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
                 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        send_all(0);
        drain();
        check("err_overflow", err, 1);

        // Reset in the middle of vector emission
        mon_en = 1'b0;
        stim = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd0, 8'd5, 8'd0, 8'd7, 8'd0, 8'hFF};
        send_all(0);
        measure("latency_rst_frame", 3);
        check("no_ready_emit", s_ready, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("vec0_before_rst", int'({out_valid, val_out}), 9'h101);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", int'({out_valid, busy, err}), 0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", s_ready, 1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Exact multiple of K after reset: no pads, PAD lasts one cycle
        ep(8'd1); ep(8'd4);
        repeat (4) ew(8'd1, 1'b0);
        ew(8'd1, 1'b0); ep(8'd0); ew(8'd1, 1'b0); ep(8'd1);
        ew(8'd1, 1'b0); ep(8'd2); ew(8'd1, 1'b1); ep(8'd3);
        ed();
        stim = '{8'd1, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        send_all(0);
        measure("latency_exact", 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
